// File: rtl/lcd_controller.sv
// HD44780 write-only controller: power-up wait, optional init sequence (LCD_INIT_SEQ_EN), then one byte per request.
// Latency: 1 setup + T_EN_CYC pulse + settle cycles per byte; o_wr_rdy is high only while idle, requests seen while busy are dropped.
module lcd_controller #(
   parameter int T_PWR_CYC = 750000,
   parameter int T_EN_CYC  = 25,
   parameter int T_CMD_CYC = 2000,
   parameter int T_CLR_CYC = 82000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_wr_vld,
   input  logic       i_wr_rs,
   input  logic [7:0] i_wr_data,
   output logic       o_wr_rdy,
   output logic       o_init_done,
   output logic       o_lcd_on,
   output logic       o_lcd_en,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic [7:0] o_lcd_data
);

   typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, PULSE, SETTLE} state_t;

   localparam int MAX_A = (T_PWR_CYC > T_CLR_CYC) ? T_PWR_CYC : T_CLR_CYC;
   localparam int MAX_B = (T_CMD_CYC > T_EN_CYC) ? T_CMD_CYC : T_EN_CYC;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] PWR_LAST = CW'(T_PWR_CYC - 1);
   localparam logic [CW-1:0] EN_LAST  = CW'(T_EN_CYC - 1);
   localparam logic [CW-1:0] CMD_LAST = CW'(T_CMD_CYC - 1);
   localparam logic [CW-1:0] CLR_LAST = CW'(T_CLR_CYC - 1);

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] settle_last;
   logic [2:0]    init_idx;
   logic [7:0]    init_byte;
   logic          rs_q;
   logic [7:0]    data_q;
   logic          lcd_on_q;
   logic          init_done_q;

   always_comb begin
      init_byte = 8'h38;
      case (init_idx)
         3'd3:    init_byte = 8'h0C;
         3'd4:    init_byte = 8'h01;
         3'd5:    init_byte = 8'h06;
         default: init_byte = 8'h38;
      endcase
   end

   // Clear and return-home need the long settle; everything else uses the short one.
   always_comb begin
      settle_last = CMD_LAST;
      if (!rs_q && (data_q inside {8'h01, 8'h02, 8'h03}))
         settle_last = CLR_LAST;
   end

   always_comb begin
      next_state = state;
      case (state)
         PWR_WAIT: begin
            if (lcd_on_q && (cnt == PWR_LAST)) begin
`ifdef LCD_INIT_SEQ_EN
               next_state = INIT;
`else
               next_state = IDLE;
`endif
            end
         end
         INIT:   next_state = SETUP;
         IDLE:   if (i_wr_vld) next_state = SETUP;
         SETUP:  next_state = PULSE;
         PULSE:  if (cnt == EN_LAST) next_state = SETTLE;
         SETTLE: begin
            if (cnt == settle_last) begin
               if (init_done_q || (init_idx == 3'd5))
                  next_state = IDLE;
               else
                  next_state = INIT;
            end
         end
         default: next_state = PWR_WAIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= PWR_WAIT;
         cnt         <= '0;
         init_idx    <= 3'd0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         lcd_on_q    <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state    <= next_state;
         lcd_on_q <= 1'b1;

         // Counter restarts on every state change and only runs in timed states.
         if (next_state != state)
            cnt <= '0;
         else if ((state == PULSE) || (state == SETTLE) ||
                  ((state == PWR_WAIT) && lcd_on_q))
            cnt <= cnt + 1'b1;

         if ((state == IDLE) && i_wr_vld) begin
            rs_q   <= i_wr_rs;
            data_q <= i_wr_data;
         end else if (state == INIT) begin
            rs_q   <= 1'b0;
            data_q <= init_byte;
         end

         if ((state == SETTLE) && (next_state == INIT))
            init_idx <= init_idx + 3'd1;

         if (next_state == IDLE)
            init_done_q <= 1'b1;
      end
   end

   assign o_wr_rdy    = (state == IDLE);
   assign o_lcd_en    = (state == PULSE);
   assign o_lcd_rw    = 1'b0;
   assign o_lcd_rs    = rs_q;
   assign o_lcd_data  = data_q;
   assign o_lcd_on    = lcd_on_q;
   assign o_init_done = init_done_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with short timing parameters.
module tb_lcd_controller;

   localparam int T_PWR = 10;
   localparam int T_EN  = 3;
   localparam int T_CMD = 5;
   localparam int T_CLR = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_vld = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       o_wr_rdy, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
   logic [7:0] o_lcd_data;

   int n_cmp = 0;
   int n_bad = 0;

   lcd_controller #(
      .T_PWR_CYC(T_PWR), .T_EN_CYC(T_EN), .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_vld(wr_vld), .i_wr_rs(wr_rs),
      .i_wr_data(wr_data), .o_wr_rdy(o_wr_rdy), .o_init_done(o_init_done),
      .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs),
      .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   // Entered at a negedge with reset asserted; releases reset and follows power-up.
   task automatic check_wake();
`ifdef LCD_INIT_SEQ_EN
      int pulses = 0;
      int hi = 0;
      int lo = 0;
      int first = 0;
      int done_at = 0;
      logic prev = 1'b0;
      logic [7:0] seq [6];
      int gap [5];
      seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      // low gap after a pulse = settle + one INIT cycle + one SETUP cycle
      gap = '{T_CMD + 2, T_CMD + 2, T_CMD + 2, T_CMD + 2, T_CLR + 2};
      rst_n = 1'b1;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (o_wr_rdy) begin
            done_at = i;
            break;
         end
         if (o_lcd_en && !prev) begin
            if (pulses == 0) first = i;
            else if (pulses < 6) begin
               n_cmp++;
               if (lo !== gap[pulses-1]) begin
                  n_bad++;
                  $display("FAIL init_gap pulse %0d got %0d want %0d", pulses, lo, gap[pulses-1]);
               end
            end
            if (pulses < 6) begin
               n_cmp++;
               if ({o_lcd_rs, o_lcd_data} !== {1'b0, seq[pulses]}) begin
                  n_bad++;
                  $display("FAIL init_byte %0d got %h want %h", pulses, {o_lcd_rs, o_lcd_data}, {1'b0, seq[pulses]});
               end
            end
            pulses++;
            hi = 0;
         end
         if (!o_lcd_en && prev) begin
            n_cmp++;
            if (hi !== T_EN) begin
               n_bad++;
               $display("FAIL init_pulse_width got %0d want %0d", hi, T_EN);
            end
            lo = 0;
         end
         if (o_lcd_en) hi++;
         else lo++;
         prev = o_lcd_en;
      end
      n_cmp++;
      if (done_at == 0) begin
         n_bad++;
         $display("FAIL init_timeout got no ready want ready within 400 cycles");
      end
      n_cmp++;
      if (first !== T_PWR + 3) begin
         n_bad++;
         $display("FAIL init_first_pulse got cycle %0d want %0d", first, T_PWR + 3);
      end
      n_cmp++;
      if (pulses !== 6) begin
         n_bad++;
         $display("FAIL init_pulse_count got %0d want 6", pulses);
      end
      n_cmp++;
      if (lo !== T_CMD) begin
         n_bad++;
         $display("FAIL init_last_settle got %0d want %0d", lo, T_CMD);
      end
`else
      int k = 0;
      logic en_seen = 1'b0;
      rst_n = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            n_cmp++;
            if (o_lcd_on !== 1'b1) begin
               n_bad++;
               $display("FAIL lcd_on got %b want 1", o_lcd_on);
            end
         end
         if (o_lcd_en) en_seen = 1'b1;
         if (o_wr_rdy) begin
            k = i;
            break;
         end
      end
      n_cmp++;
      if (k !== T_PWR + 1) begin
         n_bad++;
         $display("FAIL wake_latency got %0d want %0d", k, T_PWR + 1);
      end
      n_cmp++;
      if (en_seen !== 1'b0) begin
         n_bad++;
         $display("FAIL wake_no_en got %b want 0", en_seen);
      end
`endif
      n_cmp++;
      if (o_init_done !== 1'b1) begin
         n_bad++;
         $display("FAIL init_done got %b want 1", o_init_done);
      end
   endtask

   // Entered at a negedge while idle; returns at the negedge where ready is back.
   task automatic write_check(input logic rs, input logic [7:0] d, input int settle,
                              input logic junk, input string name);
      int lat;
      logic e;
      lat = 1 + T_EN + settle;
      n_cmp++;
      if (o_wr_rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s ready_before got %b want 1", name, o_wr_rdy);
      end
      wr_vld = 1'b1;
      wr_rs = rs;
      wr_data = d;
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         e = (k >= 2) && (k <= 1 + T_EN);
         n_cmp++;
         if ({o_lcd_en, o_wr_rdy} !== {e, (k == lat + 1)}) begin
            n_bad++;
            $display("FAIL %s en_rdy cycle %0d got %b%b want %b%b", name, k,
                     o_lcd_en, o_wr_rdy, e, (k == lat + 1));
         end
         n_cmp++;
         if ({o_lcd_rw, o_lcd_rs, o_lcd_data} !== {1'b0, rs, d}) begin
            n_bad++;
            $display("FAIL %s rw_rs_data cycle %0d got %h want %h", name, k,
                     {o_lcd_rw, o_lcd_rs, o_lcd_data}, {1'b0, rs, d});
         end
         if (k == 1) begin
            if (junk) begin
               wr_rs = 1'b1;
               wr_data = 8'h55;
            end else begin
               wr_vld = 1'b0;
            end
         end
         if (junk && (k == 1 + T_EN)) wr_vld = 1'b0;
      end
      if (junk) begin
         repeat (3) @(negedge clk);
         n_cmp++;
         if ({o_wr_rdy, o_lcd_en, o_lcd_data} !== {1'b1, 1'b0, d}) begin
            n_bad++;
            $display("FAIL %s after_ignore got %h want %h", name,
                     {o_wr_rdy, o_lcd_en, o_lcd_data}, {1'b1, 1'b0, d});
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_on, o_wr_rdy, o_init_done} !== 14'h0) begin
         n_bad++;
         $display("FAIL reset_outputs got %h want 0000",
                  {o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_on, o_wr_rdy, o_init_done});
      end
      check_wake();
   endtask

   task automatic test_data_write();
      write_check(1'b1, 8'h41, T_CMD, 1'b0, "data_41");
   endtask

   task automatic test_back_to_back();
      write_check(1'b0, 8'h01, T_CLR, 1'b0, "clear");
      write_check(1'b1, 8'h01, T_CMD, 1'b0, "data_01");
      write_check(1'b0, 8'h02, T_CLR, 1'b0, "home_02");
      write_check(1'b0, 8'h03, T_CLR, 1'b0, "home_03");
      write_check(1'b0, 8'h04, T_CMD, 1'b0, "cmd_04");
      write_check(1'b0, 8'h00, T_CMD, 1'b0, "cmd_00");
   endtask

   task automatic test_ignore_busy();
      write_check(1'b1, 8'h41, T_CMD, 1'b1, "ignore_55");
   endtask

   task automatic test_reset_mid_pulse();
      wr_vld = 1'b1;
      wr_rs = 1'b1;
      wr_data = 8'h41;
      @(negedge clk);
      wr_vld = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (o_lcd_en !== 1'b1) begin
         n_bad++;
         $display("FAIL midpulse_en_before got %b want 1", o_lcd_en);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_on, o_wr_rdy, o_init_done} !== 14'h0) begin
         n_bad++;
         $display("FAIL midpulse_reset got %h want 0000",
                  {o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_on, o_wr_rdy, o_init_done});
      end
      @(negedge clk);
      check_wake();
   endtask

   initial begin
      test_reset();
      test_data_write();
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid_pulse();
      test_data_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 The block SHALL have parameter T_PWR_CYC, default 750000, meaning the power-up wait in clock cycles (15 ms at 50 MHz).
REQ-002 The block SHALL have parameter T_EN_CYC, default 25, meaning the width of the EN high pulse in cycles.
REQ-003 The block SHALL have parameter T_CMD_CYC, default 2000, meaning the post-pulse settle time for ordinary commands and data (40 us).
REQ-004 The block SHALL have parameter T_CLR_CYC, default 82000, meaning the post-pulse settle time for clear and home commands (1.64 ms).
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port i_wr_vld, input, 1 bit: a write request from the processor IO/LSU path.
REQ-008 The block SHALL have port i_wr_rs, input, 1 bit: register select for the request (0 = command, 1 = data).
REQ-009 The block SHALL have port i_wr_data, input, 8 bits: the request byte.
REQ-010 The block SHALL have port o_wr_rdy, output, 1 bit: the block can accept a request this cycle.
REQ-011 The block SHALL have port o_init_done, output, 1 bit: power-up and initialisation are complete.
REQ-012 The block SHALL have port o_lcd_on, output, 1 bit: the LCD power/backlight enable.
REQ-013 The block SHALL have the following HD44780 pins:
- o_lcd_en, output, 1 bit
- o_lcd_rs, output, 1 bit
- o_lcd_rw, output, 1 bit
- o_lcd_data, output, 8 bits

Function
REQ-014 The FSM SHALL have exactly these states: PWR_WAIT, INIT, IDLE, SETUP, PULSE and SETTLE.
REQ-015 PWR_WAIT SHALL last T_PWR_CYC cycles after reset release, then go to INIT.
REQ-016 INIT SHALL issue, in order, the sequence 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with rs=0.
- Each byte goes through SETUP, PULSE and SETTLE.
- After the sixth byte's SETTLE, the FSM goes to IDLE.
REQ-017 o_wr_rdy SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a rising edge where i_wr_vld and o_wr_rdy are both 1.
- i_wr_rs and i_wr_data are captured on that edge.
- The FSM goes to SETUP on the next cycle.
REQ-019 If i_wr_vld is 1 while o_wr_rdy is 0, the request SHALL be ignored: not queued and no output change.
REQ-020 SETUP SHALL last exactly 1 cycle, with o_lcd_rs and o_lcd_data driven from the captured values and o_lcd_en=0.
REQ-021 PULSE SHALL drive o_lcd_en=1 for exactly T_EN_CYC consecutive cycles.
REQ-022 SETTLE SHALL drive o_lcd_en=0 for T_CLR_CYC cycles when rs=0 and data is 0x01, 0x02 or 0x03, and for T_CMD_CYC cycles otherwise; the FSM then returns to IDLE (or to the next INIT byte).
REQ-023 o_lcd_rs and o_lcd_data SHALL be held stable from SETUP through the last SETTLE cycle, and SHALL keep their last values in IDLE.
REQ-024 The busy time per accepted request SHALL be exactly 1 + T_EN_CYC + settle cycles; o_wr_rdy rises on the cycle after the last SETTLE cycle.
REQ-025 o_lcd_rw SHALL be 0 at all times (write-only interface).
REQ-026 o_lcd_on SHALL be 1 from the first cycle after reset release onward.
REQ-027 o_init_done SHALL rise on entry to IDLE and stay 1 until reset.
REQ-028 The delay counters SHALL be wide enough for max(T_PWR_CYC, T_CLR_CYC), SHALL reload on every state entry and SHALL never wrap.

Reset
REQ-029 While i_rst_n=0, the block SHALL hold the following values, asynchronously:
- state = PWR_WAIT
- all counters = 0
- o_lcd_en = 0, o_lcd_rs = 0, o_lcd_rw = 0
- o_lcd_data = 0x00
- o_lcd_on = 0
- o_wr_rdy = 0
- o_init_done = 0
REQ-030 Reset asserted mid-pulse or mid-settle SHALL force o_lcd_en=0 immediately, discard any captured request, and restart from PWR_WAIT after release.

Configuration
REQ-031 With macro LCD_INIT_SEQ_EN defined, the INIT sequence of REQ-016 SHALL execute after PWR_WAIT.
REQ-032 Without LCD_INIT_SEQ_EN, PWR_WAIT SHALL go directly to IDLE, no EN pulse SHALL occur before the first request, and o_init_done SHALL rise on that IDLE entry.

Verification
Directed scenarios use T_PWR_CYC=10, T_EN_CYC=3, T_CMD_CYC=5, T_CLR_CYC=20, with LCD_INIT_SEQ_EN defined unless stated otherwise.
REQ-033 Release reset and count EN pulses -> exactly 6 pulses with data 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06; pulse 5 is followed by 20 low cycles and the others by 5; then o_init_done=1 and o_wr_rdy=1.
REQ-034 In IDLE, write rs=1, data=0x41 -> 1 SETUP cycle, 3 EN-high cycles, 5 settle cycles, then o_wr_rdy=1 exactly 9 cycles after acceptance; rs and data stay stable throughout.
REQ-035 Write rs=0, data=0x01 -> settle lasts 20 cycles and o_wr_rdy returns 24 cycles after acceptance; a write of rs=1, data=0x01 uses the 5-cycle settle.
REQ-036 Hold i_wr_vld=1 with data=0x55 during the PULSE of an earlier 0x41 write -> 0x55 is never driven; only a request present when o_wr_rdy=1 is taken.
REQ-037 Assert reset during PULSE -> o_lcd_en=0 within the same cycle and all outputs at their reset values; after release, PWR_WAIT lasts 10 cycles and INIT restarts.
REQ-038 Build without LCD_INIT_SEQ_EN -> o_wr_rdy=1 11 cycles after reset release, with no EN activity before the first request.
